// File: rtl/game_pkg.sv
// Shared constants for the game pixel path: palette indices and sprite/tile geometry defaults.
package game_pkg;

    localparam logic [3:0] CI_TRANSPARENT = 4'd0;
    localparam logic [3:0] CI_RED         = 4'd1;
    localparam logic [3:0] CI_DKRED       = 4'd2;
    localparam logic [3:0] CI_YELLOW      = 4'd3;
    localparam logic [3:0] CI_BLACK       = 4'd4;
    localparam logic [3:0] CI_GREY        = 4'd5;
    localparam logic [3:0] CI_GREEN       = 4'd6;
    localparam logic [3:0] CI_OCHRE       = 4'd7;
    localparam logic [3:0] CI_WHITE       = 4'd8;
    localparam logic [3:0] CI_LIME        = 4'd9;
    localparam logic [3:0] CI_LTGREY      = 4'd10;

    localparam int SPR_W_DEF      = 32;
    localparam int SPR_H_DEF      = 32;
    localparam int TILE_SHIFT_DEF = 4;

endpackage

// File: rtl/sprite_hit_addr.sv
// One player's sprite: per-frame position shadow, clipped hit test and registered ROM address.
module sprite_hit_addr
    import game_pkg::*;
#(
    parameter int SPR_W = SPR_W_DEF,
    parameter int SPR_H = SPR_H_DEF,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          pix_valid,
    input  logic [9:0]    h_cnt,
    input  logic [9:0]    v_cnt,
    input  logic [9:0]    pos_x,
    input  logic [9:0]    pos_y,
    input  logic          en,
    output logic          hit_q,
    output logic [AW-1:0] addr_q
);

    logic [9:0]    x_q, y_q;
    logic          en_q;
    logic [10:0]   h_ext, v_ext, x_ext, y_ext;
    logic [9:0]    dx, dy;
    logic          hit_d;
    logic [AW-1:0] addr_d;

    // 11-bit compare: a sprite hanging past column/row 1023 is clipped, not wrapped to 0
    assign h_ext = {1'b0, h_cnt};
    assign v_ext = {1'b0, v_cnt};
    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};

    assign hit_d = pix_valid & en_q
                 & (h_ext >= x_ext) & (h_ext < x_ext + 11'(SPR_W))
                 & (v_ext >= y_ext) & (v_ext < y_ext + 11'(SPR_H));

    assign dx     = h_cnt - x_q;
    assign dy     = v_cnt - y_q;
    assign addr_d = hit_d ? AW'(AW'(dy) * AW'(SPR_W)) + AW'(dx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            en_q   <= 1'b0;
            hit_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            if (frame_start) begin
                x_q  <= pos_x;
                y_q  <= pos_y;
                en_q <= en;
            end
            hit_q  <= hit_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/sprite_layer_mixer.sv
// Three-stage sprite layer: hit/address, ROM read, then P1-over-P2 transparency mix
// with the tile coordinates and valid flag delayed alongside.
module sprite_layer_mixer
    import game_pkg::*;
#(
    parameter int SPR_W      = SPR_W_DEF,
    parameter int SPR_H      = SPR_H_DEF,
    parameter int TILE_SHIFT = TILE_SHIFT_DEF,
    parameter int AW         = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    input  logic [9:0]            h_cnt,
    input  logic [9:0]            v_cnt,
    input  logic                  frame_start,
    input  logic [9:0]            p1_x,
    input  logic [9:0]            p1_y,
    input  logic [9:0]            p2_x,
    input  logic [9:0]            p2_y,
    input  logic                  p1_en,
    input  logic                  p2_en,
    output logic [AW-1:0]         rom1_addr,
    output logic [AW-1:0]         rom2_addr,
    input  logic [3:0]            rom1_data,
    input  logic [3:0]            rom2_data,
    output logic [3:0]            color_index,
    output logic                  is_b,
    output logic [9-TILE_SHIFT:0] map_col,
    output logic [9-TILE_SHIFT:0] map_row,
    output logic                  out_valid
);

    localparam int MW = 10 - TILE_SHIFT;

    function automatic logic [4:0] mix(input logic h1, input logic [3:0] d1,
                                       input logic h2, input logic [3:0] d2);
        if (h1 && d1 != CI_TRANSPARENT) return {1'b0, d1};
        if (h2 && d2 != CI_TRANSPARENT) return {1'b1, d2};
        return {1'b0, CI_TRANSPARENT};
    endfunction

    logic          hit1_p1_q, hit2_p1_q, vld_p1_q;
    logic [MW-1:0] col_p1_q, row_p1_q;
    logic          hit1_p2_q, hit2_p2_q, vld_p2_q;
    logic [MW-1:0] col_p2_q, row_p2_q;
    logic [3:0]    color_p3_q;
    logic          is_b_p3_q, vld_p3_q;
    logic [MW-1:0] col_p3_q, row_p3_q;
    logic [4:0]    mix_d;

    // Stage 1: hit flags and ROM addresses live inside each sprite instance
    sprite_hit_addr #(.SPR_W(SPR_W), .SPR_H(SPR_H), .AW(AW)) u_p1 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .pos_x(p1_x), .pos_y(p1_y), .en(p1_en),
        .hit_q(hit1_p1_q), .addr_q(rom1_addr)
    );

    sprite_hit_addr #(.SPR_W(SPR_W), .SPR_H(SPR_H), .AW(AW)) u_p2 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .pos_x(p2_x), .pos_y(p2_y), .en(p2_en),
        .hit_q(hit2_p1_q), .addr_q(rom2_addr)
    );

    assign mix_d = mix(hit1_p2_q, rom1_data, hit2_p2_q, rom2_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q   <= 1'b0;
            col_p1_q   <= '0;
            row_p1_q   <= '0;
            hit1_p2_q  <= 1'b0;
            hit2_p2_q  <= 1'b0;
            vld_p2_q   <= 1'b0;
            col_p2_q   <= '0;
            row_p2_q   <= '0;
            color_p3_q <= CI_TRANSPARENT;
            is_b_p3_q  <= 1'b0;
            vld_p3_q   <= 1'b0;
            col_p3_q   <= '0;
            row_p3_q   <= '0;
        end else begin
            vld_p1_q   <= pix_valid;
            col_p1_q   <= h_cnt[9:TILE_SHIFT];
            row_p1_q   <= v_cnt[9:TILE_SHIFT];
            // Stage 2: ROM data is registered externally; delay the side-band to match
            hit1_p2_q  <= hit1_p1_q;
            hit2_p2_q  <= hit2_p1_q;
            vld_p2_q   <= vld_p1_q;
            col_p2_q   <= col_p1_q;
            row_p2_q   <= row_p1_q;
            // Stage 3: mix result
            color_p3_q <= mix_d[3:0];
            is_b_p3_q  <= mix_d[4];
            vld_p3_q   <= vld_p2_q;
            col_p3_q   <= col_p2_q;
            row_p3_q   <= row_p2_q;
        end
    end

    assign color_index = color_p3_q;
    assign is_b        = is_b_p3_q;
    assign out_valid   = vld_p3_q;
    assign map_col     = col_p3_q;
    assign map_row     = row_p3_q;

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Directed bench for sprite_layer_mixer with behavioural synchronous sprite ROMs.
module tb_sprite_layer_mixer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_valid, frame_start;
    logic [9:0] h_cnt, v_cnt, p1_x, p1_y, p2_x, p2_y;
    logic       p1_en, p2_en;
    logic [9:0] rom1_addr, rom2_addr;
    logic [3:0] rom1_data, rom2_data;
    logic [3:0] color_index;
    logic       is_b, out_valid;
    logic [5:0] map_col, map_row;

    logic [3:0] rom1_mem [1024];
    logic [3:0] rom2_mem [1024];

    int n_cmp = 0;
    int n_err = 0;

    sprite_layer_mixer #(.SPR_W(32), .SPR_H(32), .TILE_SHIFT(4), .AW(10)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .frame_start(frame_start), .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .p1_en(p1_en), .p2_en(p2_en), .rom1_addr(rom1_addr), .rom2_addr(rom2_addr),
        .rom1_data(rom1_data), .rom2_data(rom2_data), .color_index(color_index),
        .is_b(is_b), .map_col(map_col), .map_row(map_row), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom1_data <= rom1_mem[rom1_addr];
        rom2_data <= rom2_mem[rom2_addr];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [9:0] h, input logic [9:0] v, input logic vl);
        h_cnt = h;
        v_cnt = v;
        pix_valid = vl;
    endtask

    task automatic load_pos(input logic [9:0] ax, input logic [9:0] ay, input logic ae,
                            input logic [9:0] bx, input logic [9:0] by, input logic be);
        p1_x = ax; p1_y = ay; p1_en = ae;
        p2_x = bx; p2_y = by; p2_en = be;
        set_pix(10'd0, 10'd0, 1'b0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Sample one valid pixel, then idle until its result is visible.
    task automatic run_pixel(input logic [9:0] h, input logic [9:0] v);
        set_pix(h, v, 1'b1);
        step();
        set_pix(10'd0, 10'd0, 1'b0);
        step();
        step();
    endtask

    task automatic test_reset;
        step();
        step();
        n_cmp++; if (color_index !== 4'd0) begin n_err++; $display("FAIL reset_color got %0d exp 0", color_index); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        n_cmp++; if (rom1_addr !== 10'd0 || rom2_addr !== 10'd0) begin n_err++; $display("FAIL reset_addr got %0d/%0d exp 0/0", rom1_addr, rom2_addr); end
        n_cmp++; if (map_col !== 6'd0 || map_row !== 6'd0 || is_b !== 1'b0) begin n_err++; $display("FAIL reset_map got %0d/%0d isb %0b exp 0/0/0", map_col, map_row, is_b); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic;
        load_pos(10'd100, 10'd50, 1'b1, 10'd0, 10'd0, 1'b0);
        rom1_mem[0]  = 4'd3;
        rom1_mem[33] = 4'd7;
        set_pix(10'd100, 10'd50, 1'b1);
        step();
        n_cmp++; if (rom1_addr !== 10'd0) begin n_err++; $display("FAIL basic_addr0 got %0d exp 0", rom1_addr); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early1 got %0b exp 0", out_valid); end
        set_pix(10'd101, 10'd51, 1'b1);
        step();
        n_cmp++; if (rom1_addr !== 10'd33) begin n_err++; $display("FAIL basic_addr33 got %0d exp 33", rom1_addr); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early2 got %0b exp 0", out_valid); end
        set_pix(10'd0, 10'd0, 1'b0);
        step();
        n_cmp++; if (color_index !== 4'd3 || is_b !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL basic_pix0 got ci %0d isb %0b v %0b exp 3/0/1", color_index, is_b, out_valid); end
        n_cmp++; if (map_col !== 6'd6 || map_row !== 6'd3) begin n_err++; $display("FAIL basic_map got %0d/%0d exp 6/3", map_col, map_row); end
        step();
        n_cmp++; if (color_index !== 4'd7 || out_valid !== 1'b1) begin n_err++; $display("FAIL basic_pix1 got ci %0d v %0b exp 7/1", color_index, out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || color_index !== 4'd0) begin n_err++; $display("FAIL basic_idle got ci %0d v %0b exp 0/0", color_index, out_valid); end
    endtask

    task automatic test_priority;
        load_pos(10'd200, 10'd200, 1'b1, 10'd200, 10'd200, 1'b1);
        rom1_mem[0] = 4'd0;
        rom2_mem[0] = 4'd1;
        run_pixel(10'd200, 10'd200);
        n_cmp++; if (color_index !== 4'd1 || is_b !== 1'b1) begin n_err++; $display("FAIL prio_p2 got ci %0d isb %0b exp 1/1", color_index, is_b); end
        n_cmp++; if (map_col !== 6'd12 || map_row !== 6'd12) begin n_err++; $display("FAIL prio_map got %0d/%0d exp 12/12", map_col, map_row); end
        rom1_mem[0] = 4'd2;
        run_pixel(10'd200, 10'd200);
        n_cmp++; if (color_index !== 4'd2 || is_b !== 1'b0) begin n_err++; $display("FAIL prio_p1 got ci %0d isb %0b exp 2/0", color_index, is_b); end
        rom1_mem[0] = 4'd0;
        rom2_mem[0] = 4'd0;
        run_pixel(10'd200, 10'd200);
        n_cmp++; if (color_index !== 4'd0 || is_b !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL prio_none got ci %0d isb %0b v %0b exp 0/0/1", color_index, is_b, out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] hs [10];
        logic [3:0] exp_ci [10];
        logic [9:0] exp_ad [10];
        logic [5:0] exp_col [10];
        load_pos(10'd1010, 10'd100, 1'b1, 10'd0, 10'd0, 1'b0);
        for (int a = 5; a <= 13; a++) rom1_mem[a] = 4'(a);
        rom1_mem[17] = 4'd15;
        for (int i = 0; i < 9; i++) begin
            hs[i]      = 10'(1015 + i);
            exp_ci[i]  = 4'(5 + i);
            exp_ad[i]  = 10'(5 + i);
            exp_col[i] = 6'd63;
        end
        hs[9] = 10'd3; exp_ci[9] = 4'd0; exp_ad[9] = 10'd0; exp_col[9] = 6'd0;
        for (int n = 0; n < 12; n++) begin
            if (n < 10) set_pix(hs[n], 10'd100, 1'b1);
            else set_pix(10'd0, 10'd0, 1'b0);
            step();
            if (n < 10) begin
                n_cmp++; if (rom1_addr !== exp_ad[n]) begin n_err++; $display("FAIL clip_addr[%0d] got %0d exp %0d", n, rom1_addr, exp_ad[n]); end
            end
            if (n >= 2) begin
                n_cmp++;
                if (color_index !== exp_ci[n-2] || out_valid !== 1'b1 || map_col !== exp_col[n-2] || map_row !== 6'd6) begin
                    n_err++;
                    $display("FAIL clip_out[%0d] got ci %0d v %0b col %0d row %0d exp %0d/1/%0d/6", n-2, color_index, out_valid, map_col, map_row, exp_ci[n-2], exp_col[n-2]);
                end
            end
        end
    endtask

    task automatic test_shadow;
        load_pos(10'd100, 10'd50, 1'b1, 10'd0, 10'd0, 1'b0);
        rom1_mem[0] = 4'd4;
        p1_x = 10'd300;
        run_pixel(10'd100, 10'd50);
        n_cmp++; if (color_index !== 4'd4) begin n_err++; $display("FAIL shadow_old_hit got %0d exp 4", color_index); end
        run_pixel(10'd300, 10'd50);
        n_cmp++; if (color_index !== 4'd0 || out_valid !== 1'b1) begin n_err++; $display("FAIL shadow_new_early got ci %0d v %0b exp 0/1", color_index, out_valid); end
        set_pix(10'd100, 10'd50, 1'b1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        set_pix(10'd0, 10'd0, 1'b0);
        step();
        step();
        n_cmp++; if (color_index !== 4'd4) begin n_err++; $display("FAIL shadow_fs_cycle got %0d exp 4", color_index); end
        run_pixel(10'd100, 10'd50);
        n_cmp++; if (color_index !== 4'd0) begin n_err++; $display("FAIL shadow_old_miss got %0d exp 0", color_index); end
        run_pixel(10'd300, 10'd50);
        n_cmp++; if (color_index !== 4'd4 || is_b !== 1'b0) begin n_err++; $display("FAIL shadow_new_hit got ci %0d isb %0b exp 4/0", color_index, is_b); end
    endtask

    task automatic test_reset_midrun;
        load_pos(10'd100, 10'd50, 1'b1, 10'd0, 10'd0, 1'b0);
        set_pix(10'd100, 10'd50, 1'b1);
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (out_valid !== 1'b1 || color_index !== 4'd4) begin n_err++; $display("FAIL mid_stream got ci %0d v %0b exp 4/1", color_index, out_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (color_index !== 4'd0 || out_valid !== 1'b0 || is_b !== 1'b0) begin n_err++; $display("FAIL mid_async got ci %0d v %0b isb %0b exp 0/0/0", color_index, out_valid, is_b); end
        n_cmp++; if (map_col !== 6'd0 || map_row !== 6'd0 || rom1_addr !== 10'd0) begin n_err++; $display("FAIL mid_async_map got %0d/%0d addr %0d exp 0/0/0", map_col, map_row, rom1_addr); end
        step();
        set_pix(10'd0, 10'd0, 1'b0);
        rst = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_flush got %0b exp 0", out_valid); end
        set_pix(10'd100, 10'd50, 1'b1);
        step();
        set_pix(10'd0, 10'd0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_lat1 got %0b exp 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_lat2 got %0b exp 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || color_index !== 4'd0) begin n_err++; $display("FAIL mid_lat3 got v %0b ci %0d exp 1/0", out_valid, color_index); end
        step();
    endtask

    task automatic test_invalid;
        load_pos(10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 1'b0);
        rom1_mem[330] = 4'd6;
        set_pix(10'd10, 10'd10, 1'b0);
        step();
        n_cmp++; if (rom1_addr !== 10'd0) begin n_err++; $display("FAIL inv_addr got %0d exp 0", rom1_addr); end
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0 || color_index !== 4'd0 || is_b !== 1'b0) begin n_err++; $display("FAIL inv_out got ci %0d v %0b isb %0b exp 0/0/0", color_index, out_valid, is_b); end
        n_cmp++; if (map_col !== 6'd0 || map_row !== 6'd0) begin n_err++; $display("FAIL inv_map got %0d/%0d exp 0/0", map_col, map_row); end
        run_pixel(10'd10, 10'd10);
        n_cmp++; if (out_valid !== 1'b1 || color_index !== 4'd6) begin n_err++; $display("FAIL inv_valid_hit got ci %0d v %0b exp 6/1", color_index, out_valid); end
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        set_pix(10'd0, 10'd0, 1'b0);
        p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0;
        p1_en = 1'b0; p2_en = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            rom1_mem[i] = 4'd0;
            rom2_mem[i] = 4'd0;
        end
        test_reset();
        test_basic();
        test_priority();
        test_back_to_back();
        test_shadow();
        test_reset_midrun();
        test_invalid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_layer_mixer.md
# sprite_layer_mixer

Pixel-pipeline stage directly upstream of the color decoders. Given the VGA scan position, it checks two player sprites for a hit and fetches their 4-bit palette indices from synchronous sprite ROMs. It resolves priority and transparency, then delivers a registered, aligned `color_index`/`is_b` pair to `color_decoder` and a tile coordinate pair for the big-map path. Sprite positions are shadowed once per frame so sprites do not tear mid-frame.

## Interface
Parameters:
- `SPR_W`, 32: sprite width in pixels, power of two.
- `SPR_H`, 32: sprite height in pixels.
- `TILE_SHIFT`, 4: log2 of the big-map tile size in pixels.
- `AW`, 10: ROM address width; must equal clog2(`SPR_W`*`SPR_H`).

Ports:
- `clk` in 1: pixel clock, the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `pix_valid` in 1: `h_cnt`/`v_cnt` lie in the visible area.
- `h_cnt`, `v_cnt` in 10 each: current scan position.
- `frame_start` in 1: one-cycle pulse at the start of vertical blank.
- `p1_x`, `p1_y`, `p2_x`, `p2_y` in 10 each: sprite top-left corners, live from game logic.
- `p1_en`, `p2_en` in 1 each: sprite visible.
- `rom1_addr`, `rom2_addr` out `AW` each: registered sprite ROM addresses.
- `rom1_data`, `rom2_data` in 4 each: ROM read data, returned 1 cycle after the address edge.
- `color_index` out 4: palette index to `color_decoder`; 0 means transparent.
- `is_b` out 1: winning pixel belongs to player 2, which selects the blue tint.
- `map_col`, `map_row` out `10-TILE_SHIFT` each: big-map tile coordinates of the pixel.
- `out_valid` out 1: outputs correspond to a visible pixel.

## Operation
- Shadow registers:
  - On `frame_start`, latch `p*_x`, `p*_y` and `p*_en`.
  - Hit tests use only the shadowed values.
  - In a `frame_start` cycle, the pixel sampled that same cycle still uses the old shadow.
- Hit test for sprite n, computed in 11-bit arithmetic so no wrap is possible:
  - `hit_n = pix_valid & en_n & (h_cnt >= x_n) & (h_cnt < x_n+SPR_W) & (v_cnt >= y_n) & (v_cnt < y_n+SPR_H)`.
  - A sprite extending past 1023 is clipped, never wrapped.
- ROM address: `(v_cnt - y_n)*SPR_W + (h_cnt - x_n)`, truncated to `AW`. When `hit_n = 0`, the address register holds 0.
- Mix, in the last stage:
  - Candidate n is opaque iff `hit_n` is set and `rom_n_data != 0`.
  - P1 has priority: if P1 is opaque, output P1's data with `is_b = 0`.
  - Else if P2 is opaque, output P2's data with `is_b = 1`.
  - Else output `color_index = 0`, `is_b = 0`. The downstream mux then shows the big map.
- Tile coordinates: `map_col = h_cnt >> TILE_SHIFT`, `map_row = v_cnt >> TILE_SHIFT`, carried through the pipeline unchanged.
- When `pix_valid = 0`: both hits are forced to 0, and the corresponding output cycle has `out_valid = 0`, `color_index = 0`, `is_b = 0`.

## Timing
- Three-stage pipeline; with inputs sampled in cycle k:
  - S1 (edge ending k): hit flags, ROM addresses, tile coordinates and valid are registered.
  - S2 (edge ending k+1): the ROM registers its data; hit, tile and valid registers are delayed one stage.
  - S3 (edge ending k+2): mix result is registered.
  - Outputs are visible in cycle k+3; latency is 3 clocks, throughput 1 pixel per clock.
- `rom*_addr` are visible in cycle k+1.
- Reset, asynchronous:
  - `color_index = 0`, `is_b = 0`, `out_valid = 0`, `map_col = 0`, `map_row = 0`, `rom*_addr = 0`.
  - All pipeline valid/hit bits are cleared.
  - Shadow positions are cleared to 0 and shadow enables to 0.
- Reset mid-line flushes all in-flight pixels. The first valid output appears 3 cycles after the first `pix_valid` following reset release.
- No handshake and no back-pressure: the downstream must accept every cycle.

## Structure
- Shared package `game_pkg`:
  - Palette index constants: `CI_TRANSPARENT=0`, `CI_RED=1`, `CI_DKRED=2`, `CI_YELLOW=3`, `CI_BLACK=4`, `CI_GREY=5`, `CI_GREEN=6`, `CI_OCHRE=7`, `CI_WHITE=8`, `CI_LIME=9`, `CI_LTGREY=10`.
  - `SPR_W`, `SPR_H` and `TILE_SHIFT` defaults.
- One sub-module, `sprite_hit_addr`:
  - Contains the shadow register, the 11-bit hit compare and the address register.
  - Instantiated twice, once per player.
- The mixer and delay lines stay in the top module.

## Test plan
- P1 at (100,50), enabled; ROM1 returns 3 at address 0; drive (100,50) valid. Expect `color_index = 3`, `is_b = 0`, `out_valid = 1` exactly 3 clocks later, and `rom1_addr = 0` after 1 clock.
- P1 and P2 both at (200,200); ROM1 = 0, ROM2 = 1 at the overlap. Expect `color_index = 1`, `is_b = 1`. Then set ROM1 = 2: expect `color_index = 2`, `is_b = 0`.
- P1 at x=1010; drive `h_cnt = 1015` (hit, address 5), then sweep `h_cnt` up to 1023 without wrap; also drive `h_cnt = 3` on the same row. Expect no hit at `h_cnt = 3`.
- Change `p1_x` from 100 to 300 mid-frame. Pixel (100,y) still hits until after `frame_start`, then misses; (300,y) hits from the next frame.
- Assert `rst` during a run of valid pixels. Expect all outputs 0 immediately (async); after release, the first `out_valid` appears 3 clocks after the first `pix_valid`.
- `pix_valid = 0` at (10,10), which lies inside P1. Expect `out_valid = 0`, `color_index = 0`; `map_col`/`map_row` still equal 0/0 for `TILE_SHIFT = 4`.
